// File: rtl/dff_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dff_rr_arbiter_pkg
// Brief   : Shared types and helpers for the round-robin register arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package dff_rr_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int N_REQ_DEF = 4;
    localparam int MAX_REQ   = 16;
    localparam int PTR_W     = $clog2(N_REQ_DEF);

    // Widest grant vector; callers narrow it to their own requester count.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : dff_rr_arbiter_rr_pick
// Brief   : Combinational rotating-priority picker (search from i_ptr upward).
// Rev     : 1.0  initial release
// ============================================================================
module dff_rr_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_win,
    output logic             o_any_req
);

    assign o_any_req = |i_req;

    // Scanning offsets downward leaves the lowest matching offset as winner.
    always_comb begin
        o_win = '0;
        for (int p = 0; p < N_REQ; p++) begin
            if (i_ptr == IDX_W'(p)) begin
                for (int i = N_REQ - 1; i >= 0; i--) begin
                    if (i_req[(p + i) % N_REQ]) begin
                        o_win = IDX_W'((p + i) % N_REQ);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dff_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dff_rr_arbiter
// Brief   : Round-robin write arbiter for one shared register.
//           Optional owner lock enabled by defining ARB_LOCK_EN.
// Rev     : 1.0  initial release
// ============================================================================
module dff_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int CW    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DW-1:0]       wdata,
    input  logic [N_REQ-1:0]          lock,
    output logic [N_REQ-1:0]          gnt,
    output logic [DW-1:0]             q,
    output logic                      q_valid,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic [CW-1:0]             wr_count
);

    import dff_rr_arbiter_pkg::*;

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [N_REQ-1:0]  r_gnt;
    logic [DW-1:0]     r_q;
    logic              r_q_valid;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_ptr;
    logic [CW-1:0]     r_wr_count;

    logic [IDX_W-1:0]  w_win;
    logic              w_any_req;
    logic              w_lock_win;
    logic              w_lock_own;
    logic              w_do_write;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_ptr_nxt;
    logic [DW-1:0]     w_lane [N_REQ];

    function automatic logic [IDX_W-1:0] f_next_idx(input logic [IDX_W-1:0] v);
        return (v == IDX_W'(N_REQ - 1)) ? '0 : v + IDX_W'(1);
    endfunction

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign w_lane[gi] = wdata[gi*DW +: DW];
        end
    endgenerate

    dff_rr_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_win     (w_win),
        .o_any_req (w_any_req)
    );

`ifdef ARB_LOCK_EN
    assign w_lock_win = lock[w_win];
    // Lock persists only while the owner both requests and holds lock.
    assign w_lock_own = lock[r_owner] & req[r_owner];
`else
    logic w_unused_lock;
    assign w_unused_lock = ^lock;
    assign w_lock_win    = 1'b0;
    assign w_lock_own    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_do_write  = 1'b0;
        w_wr_idx    = w_win;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_do_write = 1'b1;
                    w_wr_idx   = w_win;
                    w_ptr_nxt  = f_next_idx(w_win);
                    if (w_lock_win) begin
                        w_state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (w_lock_own) begin
                    w_do_write = 1'b1;
                    w_wr_idx   = r_owner;
                end else begin
                    // Release edge: no grant, priority resumes after the owner.
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = f_next_idx(r_owner);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt      <= '0;
            r_q        <= '0;
            r_q_valid  <= 1'b0;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_wr_count <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
            if (w_do_write) begin
                r_gnt      <= N_REQ'(onehot(4'(w_wr_idx)));
                r_q        <= w_lane[w_wr_idx];
                r_owner    <= w_wr_idx;
                r_wr_count <= r_wr_count + CW'(1);
                r_q_valid  <= 1'b1;
            end else begin
                r_gnt <= '0;
            end
        end
    end

    assign gnt      = r_gnt;
    assign q        = r_q;
    assign q_valid  = r_q_valid;
    assign owner    = r_owner;
    assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_dff_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dff_rr_arbiter
// Brief   : Self-checking bench for dff_rr_arbiter against a behavioural model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dff_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 4;
`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    lock;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   q;
    logic            q_valid;
    logic [1:0]      owner;
    logic [CW-1:0]   wr_count;

    always #5 clk = ~clk;

    dff_rr_arbiter #(
        .N_REQ (N),
        .DW    (DW),
        .CW    (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .lock     (lock),
        .gnt      (gnt),
        .q        (q),
        .q_valid  (q_valid),
        .owner    (owner),
        .wr_count (wr_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [N-1:0]  m_gnt;
    logic [DW-1:0] m_q;
    logic          m_valid;
    logic [1:0]    m_owner;
    logic [CW-1:0] m_cnt;
    int            m_ptr;
    bit            m_locked;

    task automatic model_reset();
        m_gnt = '0; m_q = '0; m_valid = 1'b0; m_owner = '0;
        m_cnt = '0; m_ptr = 0; m_locked = 1'b0;
    endtask

    task automatic model_step();
        int w;
        int c;
        w = -1;
        m_gnt = '0;
        if (m_locked) begin
            if (((req >> m_owner) & 4'b1) != 0 && ((lock >> m_owner) & 4'b1) != 0) begin
                w = int'(m_owner);
            end else begin
                m_locked = 1'b0;
                m_ptr = (int'(m_owner) + 1) % N;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (w < 0 && ((req >> c) & 4'b1) != 0) w = c;
            end
            if (w >= 0 && LOCK_EN && ((lock >> w) & 4'b1) != 0) m_locked = 1'b1;
        end
        if (w >= 0) begin
            m_gnt   = 4'(1 << w);
            m_q     = wdata[w*DW +: DW];
            m_owner = 2'(w);
            m_cnt   = m_cnt + 4'd1;
            m_valid = 1'b1;
            m_ptr   = (w + 1) % N;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; wdata = '0; lock = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({gnt, q, q_valid, owner, wr_count} !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_init: got %h expected %h", {gnt, q, q_valid, owner, wr_count}, 19'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        wdata = {$urandom, 8'h00} | 32'h0101_0101;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({gnt, q, q_valid, wr_count} !== 17'h0) begin
            n_bad++;
            $display("FAIL reset_async: got %h expected %h", {gnt, q, q_valid, wr_count}, 17'h0);
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({gnt, q, q_valid, owner, wr_count} !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_hold: got %h expected %h", {gnt, q, q_valid, owner, wr_count}, 19'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        tick();
        n_cmp++;
        if ({gnt, q, q_valid, owner, wr_count} !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_release: got %h expected %h", {gnt, q, q_valid, owner, wr_count}, 19'h0);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        wdata = {8'h33, 8'hA5, 8'h22, 8'h11};
        tick();
        req = '0;
        n_cmp++;
        if ({gnt, q, q_valid, owner, wr_count} !== {4'b0100, 8'hA5, 1'b1, 2'd2, 4'd1}) begin
            n_bad++;
            $display("FAIL single_grant: got %h expected %h", {gnt, q, q_valid, owner, wr_count},
                     {4'b0100, 8'hA5, 1'b1, 2'd2, 4'd1});
        end
        tick();
        n_cmp++;
        if ({gnt, q, q_valid, owner, wr_count} !== {4'b0000, 8'hA5, 1'b1, 2'd2, 4'd1}) begin
            n_bad++;
            $display("FAIL single_pulse: got %h expected %h", {gnt, q, q_valid, owner, wr_count},
                     {4'b0000, 8'hA5, 1'b1, 2'd2, 4'd1});
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0]  eg;
        logic [DW-1:0] eq;
        do_reset();
        req = 4'b1111;
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 8; k++) begin
            tick();
            eg = 4'(1 << (k % 4));
            eq = 8'(8'h10 + k % 4);
            n_cmp++;
            if ({gnt, q} !== {eg, eq}) begin
                n_bad++;
                $display("FAIL round_robin[%0d]: got gnt=%b q=%h expected gnt=%b q=%h", k, gnt, q, eg, eq);
            end
            n_cmp++;
            if ({gnt, q, q_valid, owner, wr_count} !== {m_gnt, m_q, m_valid, m_owner, m_cnt}) begin
                n_bad++;
                $display("FAIL round_robin_model[%0d]: got %h expected %h", k,
                         {gnt, q, q_valid, owner, wr_count}, {m_gnt, m_q, m_valid, m_owner, m_cnt});
            end
        end
        req = '0;
    endtask

    task automatic test_skip_idle();
        logic [N-1:0] exp_seq [3];
        exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b1000;
        do_reset();
        req = 4'b0001;
        wdata = 32'hD3C2_B1A0;
        tick();
        req = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (gnt !== exp_seq[k]) begin
                n_bad++;
                $display("FAIL skip_idle[%0d]: got gnt=%b expected gnt=%b", k, gnt, exp_seq[k]);
            end
        end
        req = '0;
    endtask

    task automatic test_counter_wrap();
        do_reset();
        req = 4'b0001;
        wdata = 32'h0000_0077;
        repeat (17) tick();
        req = '0;
        n_cmp++;
        if (wr_count !== 4'd1 || m_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL counter_wrap: got %0d expected %0d", wr_count, 1);
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            r = $urandom;
            req   = (r[31:29] == 3'b000) ? 4'b0000 : r[3:0];
            lock  = (r[28:27] == 2'b00) ? r[7:4] : 4'b0000;
            wdata = $urandom;
            tick();
            n_cmp++;
            if ({gnt, q, q_valid, owner, wr_count} !== {m_gnt, m_q, m_valid, m_owner, m_cnt}) begin
                n_bad++;
                $display("FAIL random[%0d]: got %h expected %h", k,
                         {gnt, q, q_valid, owner, wr_count}, {m_gnt, m_q, m_valid, m_owner, m_cnt});
            end
        end
        req = '0; lock = '0;
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        lock = '0;
        req = 4'b0001;
        wdata = 32'h4433_2211;
        tick();
        req = 4'b1111;
        lock = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (gnt !== 4'b0010 || m_gnt !== 4'b0010) begin
                n_bad++;
                $display("FAIL lock_hold[%0d]: got gnt=%b expected gnt=%b", k, gnt, 4'b0010);
            end
        end
        lock = '0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_bad++;
            $display("FAIL lock_release: got gnt=%b expected gnt=%b", gnt, 4'b0000);
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_bad++;
            $display("FAIL lock_next: got gnt=%b expected gnt=%b", gnt, 4'b0100);
        end
        req = '0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_skip_idle();
        test_counter_wrap();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dff_rr_arbiter.md
Name: dff_rr_arbiter

Overview:
Round-robin write arbiter that shares one DW-bit async-reset register, built from the team's flip-flop cells, among N_REQ requesters. Each cycle it picks at most one requesting client by rotating priority, loads that client's data into the shared register, and returns a one-cycle grant pulse. It sits in front of any shared configuration or data register written by several sequencers.

Parameters:
N_REQ, 4, number of requesters (2..16)
DW, 8, width of the shared register and of each write-data lane
CW, 16, width of the write counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req  input  N_REQ  per-requester write request, level
wdata  input  N_REQ*DW  packed write data; lane i is bits [i*DW +: DW]
lock  input  N_REQ  per-requester lock request; used only when ARB_LOCK_EN is defined, ignored otherwise
gnt  output  N_REQ  one-hot grant, registered
q  output  DW  shared register contents
q_valid  output  1  set on the first write after reset, sticky
owner  output  clog2(N_REQ)  index of the last granted requester
wr_count  output  CW  total completed writes, wraps modulo 2^CW

Behaviour:
- Reset (async, immediate, mid-operation included): gnt=0, q=0, q_valid=0, owner=0, wr_count=0, rotating pointer ptr=0, state=IDLE. No grant issues on the first edge after deassertion unless req is high at that edge.
- Priority: search starts at ptr and goes ptr, ptr+1, … N_REQ-1, 0, … ptr-1. The first requester with req[i]=1 wins.
- At each rising edge with any req bit set, in state IDLE:
  - gnt <= onehot(win)
  - q <= wdata lane win
  - owner <= win
  - ptr <= win+1, wrapping to 0 after N_REQ-1
  - wr_count <= wr_count+1
  - q_valid <= 1
- At an edge with no req bit set: gnt <= 0. q, owner, ptr and wr_count hold.
- Latency: req sampled at edge k; gnt and q are visible after edge k. gnt is a single-cycle pulse.
- A requester holding req high keeps competing. It wins again only after every other active requester has been served (fairness bound N_REQ cycles).
- Requester handshake: the requester drops req in the cycle after it sees gnt. If it does not, this is treated as a new write.
- wr_count wraps from 2^CW-1 to 0 with no flag.
- FSM states:
  - IDLE: arbitrating.
  - LOCKED: reachable only with ARB_LOCK_EN.
- Simultaneous requests from all N_REQ clients: exactly one gnt bit per cycle, rotating.

Optional Feature:
ARB_LOCK_EN
- Defined:
  - If the winner has lock[win]=1 at the grant edge, the FSM goes IDLE->LOCKED.
  - In LOCKED, only owner is served. Each edge with req[owner]=1 writes its lane, pulses gnt[owner] and increments wr_count. Other requests are stalled, not dropped.
  - LOCKED->IDLE on the first edge where lock[owner]=0 or req[owner]=0. That edge issues no grant; ptr = owner+1.
  - Async reset from LOCKED returns the FSM to IDLE.
- Not defined: the lock input is unconnected internally, the FSM never leaves IDLE, and behaviour is as above.

Decomposition:
- Package dff_rr_arbiter_pkg:
  - state enum {IDLE, LOCKED}
  - localparam PTR_W = clog2(N_REQ)
  - function onehot(idx)
- Sub-module rr_pick: purely combinational rotating priority picker.
  - Inputs: req, ptr.
  - Outputs: win index and any_req.
  - Instantiated once.
- The shared register, pointer, counter and FSM stay in the top module.

Test Plan:
- Reset: assert rst for 3 cycles mid-stream with req=4'b1111 -> gnt=0, q=8'h00, q_valid=0 and wr_count=0 immediately, without waiting for a clock edge.
- Single requester: req=4'b0100 with lane2=8'hA5 for 1 cycle -> next cycle gnt=4'b0100, q=8'hA5, owner=2, wr_count=1, q_valid=1.
- Round-robin under full load: req=4'b1111 held for 8 cycles with lane i=8'h10+i -> gnt sequence 0001,0010,0100,1000 repeated; q sequence 10,11,12,13,10,11,12,13.
- Skip idle clients: ptr=1 and req=4'b1001 -> grant 3 then 0, then 3 again if both stay high.
- Counter wrap: with CW=4, perform 17 writes -> wr_count=1.
- ARB_LOCK_EN: requester 1 wins with lock[1]=1 while req=4'b1111 for 5 cycles -> gnt=4'b0010 every cycle. Drop lock[1] -> one idle edge, then grant 2 next.
